// File: rtl/if_id_latch.sv
// rtl/if_id_latch.sv - IF/ID pipeline register with bubble/flush/stall control and immediate-format decode
module if_id_latch #(
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_inc_in,
    input  logic        fetch_valid,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] instr_out,
    output logic [15:0] pc_inc_out,
    output logic        valid_out,
    output logic [7:0]  imm_data,
    output logic        imm_len,
    output logic        imm_sign,
    output logic        halt_seen
);

    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRLI  = 5'b10111;

    logic       load_en;
    logic [4:0] opcode;

    assign load_en = !flush && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_out  <= NOP_INSTR;
            pc_inc_out <= 16'h0000;
            valid_out  <= 1'b0;
        end else if (flush) begin
            // Squash keeps the PC so decode still sees where the bubble came from.
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
        end else if (!stall) begin
            instr_out  <= fetch_valid ? instr_in : NOP_INSTR;
            pc_inc_out <= pc_inc_in;
            valid_out  <= fetch_valid;
        end
    end

    // Sticky until reset; only a HALT actually accepted into decode counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_seen <= 1'b0;
        end else if (load_en && fetch_valid && (instr_in[15:11] == OP_HALT)) begin
            halt_seen <= 1'b1;
        end
    end

    assign opcode   = instr_out[15:11];
    assign imm_data = instr_out[7:0];

    always_comb begin
        imm_len = 1'b0;
        case (opcode)
            OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI,
            OP_ST, OP_LD, OP_STU,
            OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: imm_len = 1'b1;
            default:                            imm_len = 1'b0;
        endcase
    end

    always_comb begin
        imm_sign = 1'b1;
        case (opcode)
            OP_XORI, OP_ANDNI, OP_SLBI,
            OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: imm_sign = 1'b0;
            default:                            imm_sign = 1'b1;
        endcase
    end

endmodule
